// File: rtl/speed_pkg.sv
// Shared constants for the shift-command interface between the master FSM and shift_rate_ctrl.
// Defaults for the tick rate plus bit positions inside the 4-bit command vector.
package speed_pkg;

  localparam int BASE_PERIOD_DEF = 16;
  localparam int MAX_EXP_DEF     = 7;
  localparam int INIT_EXP_DEF    = 3;

  localparam int CMD_W  = 4;
  localparam int CMD_L1 = 0;
  localparam int CMD_L2 = 1;
  localparam int CMD_R1 = 2;
  localparam int CMD_R2 = 3;

  typedef logic [CMD_W-1:0] cmd_t;

  // More than one bit set means the master issued conflicting commands on one edge.
  function automatic logic cmd_multi(input cmd_t c);
    return (c & (c - cmd_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/shift_rate_ctrl_tick_gen.sv
// Period down-pacing counter: one-cycle tick every `period` cycles, restartable.
// A restart clears the count and suppresses any coincident terminal tick.
module tick_gen
#(
  parameter int CNT_W = 24
)(
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] period,
  input  logic             restart,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic             terminal;

  assign terminal = (cnt == (period - CNT_W'(1)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (terminal) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_rate_ctrl.sv
// Rate exponent control: edge-detects shift commands, updates exp/period, flags conflicts.
// Build option SHIFT_WRAP_EN: exponent arithmetic wraps modulo MAX_EXP+1 instead of saturating.
module shift_rate_ctrl
  import speed_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int EXP_W       = 3,
  parameter int BASE_PERIOD = BASE_PERIOD_DEF,
  parameter int MAX_EXP     = MAX_EXP_DEF,
  parameter int INIT_EXP    = INIT_EXP_DEF
)(
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_left_1,
  input  logic             shift_left_2,
  input  logic             shift_right_1,
  input  logic             shift_right_2,
  output logic [EXP_W-1:0] exp,
  output logic [CNT_W-1:0] period,
  output logic             tick,
  output logic             cmd_err
);

  // Two extra bits so exp+2 at the top and exp-2 at zero are both representable.
  localparam int SUM_W = EXP_W + 2;

  localparam logic signed [SUM_W-1:0] D_P1   = SUM_W'(1);
  localparam logic signed [SUM_W-1:0] D_P2   = SUM_W'(2);
  localparam logic signed [SUM_W-1:0] D_M1   = SUM_W'(-1);
  localparam logic signed [SUM_W-1:0] D_M2   = SUM_W'(-2);
  localparam logic signed [SUM_W-1:0] ZERO_S = '0;
  localparam logic signed [SUM_W-1:0] MAX_S  = SUM_W'(MAX_EXP);
`ifdef SHIFT_WRAP_EN
  localparam logic signed [SUM_W-1:0] MOD_S  = SUM_W'(MAX_EXP + 1);
`endif

  localparam logic [EXP_W-1:0] INIT_EXP_V  = EXP_W'(INIT_EXP);
  localparam logic [CNT_W-1:0] INIT_PERIOD = CNT_W'(BASE_PERIOD) << INIT_EXP;

  cmd_t                     cmd;
  cmd_t                     cmd_q;
  cmd_t                     rise;
  logic                     multi;
  logic                     single;
  logic signed [SUM_W-1:0]  delta;
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  target;
  logic        [EXP_W-1:0]  exp_nxt;
  logic                     changed;

  always_comb begin
    cmd         = '0;
    cmd[CMD_L1] = shift_left_1;
    cmd[CMD_L2] = shift_left_2;
    cmd[CMD_R1] = shift_right_1;
    cmd[CMD_R2] = shift_right_2;
  end

  assign rise   = cmd & ~cmd_q;
  assign multi  = cmd_multi(rise);
  assign single = (rise != '0) && !multi;

  always_comb begin
    delta = ZERO_S;
    if (rise[CMD_L1])      delta = D_P1;
    else if (rise[CMD_L2]) delta = D_P2;
    else if (rise[CMD_R1]) delta = D_M1;
    else if (rise[CMD_R2]) delta = D_M2;
  end

  assign sum = $signed({2'b00, exp}) + delta;

  always_comb begin
    target = sum;
`ifdef SHIFT_WRAP_EN
    if (sum > MAX_S)       target = sum - MOD_S;
    else if (sum < ZERO_S) target = sum + MOD_S;
`else
    if (sum > MAX_S)       target = MAX_S;
    else if (sum < ZERO_S) target = ZERO_S;
`endif
  end

  assign exp_nxt = target[EXP_W-1:0];
  // A saturated no-op must not restart the tick counter.
  assign changed = single && (exp_nxt != exp);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_q   <= '0;
      exp     <= INIT_EXP_V;
      period  <= INIT_PERIOD;
      cmd_err <= 1'b0;
    end else begin
      cmd_q   <= cmd;
      cmd_err <= multi;
      if (changed) begin
        exp    <= exp_nxt;
        period <= CNT_W'(BASE_PERIOD) << exp_nxt;
      end
    end
  end

  tick_gen #(
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .clock   (clock),
    .reset   (reset),
    .period  (period),
    .restart (changed),
    .tick    (tick)
  );

endmodule
